ram_4x16_arbiter: RTL and testbench
===================================

# ram_4x16_arbiter

Two-port round-robin access controller for the 4-word x 16-bit RAM. Two requesters issue single-word read or write transactions over a req/ack handshake. The block serialises them onto the RAM's single rw/addr/data port, captures read data, and returns it with a one-cycle ack pulse. It sits between the two datapath masters and the RAM instance and is the only driver of the RAM control port.

## Interface
- DATA_W, 16, word width; must equal the RAM data width
- ADDR_W, 2, address width; the RAM holds 2**ADDR_W words
- clk  in  1  system clock; all state changes on the rising edge
- clr  in  1  asynchronous, active-low reset
- req0 / req1  in  1  transaction request from port 0 / 1; held high until ack
- we0 / we1  in  1  1 = write, 0 = read; valid while req is high
- addr0 / addr1  in  ADDR_W  word address; valid while req is high
- wdata0 / wdata1  in  DATA_W  write data; valid while req is high
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DATA_W  read result; valid in the ack cycle and held until that port's next read completes
- ram_rw  out  1  RAM write enable (1 = write on the clk edge)
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data
- busy  out  1  high in any state other than IDLE

## Operation
- States: INIT (only with the macro), IDLE, ACCESS, HOLD.
- Inputs are sampled only in IDLE. The winner's we, addr and wdata are latched into internal registers, so requester inputs may change after the grant edge.
- IDLE arbitration:
  - A port is eligible if its req is high and its ack is not high this cycle. This masks the req still held during the ack cycle.
  - One eligible port: that port wins.
  - Both eligible: the port other than `last` wins.
  - `last` updates to the winner. The next state is ACCESS.
  - No eligible port: stay in IDLE.
- ACCESS (1 cycle):
  - ram_addr = latched addr; ram_rw = latched we; ram_din = latched wdata.
  - A write commits on the closing edge.
  - Next state is HOLD.
- HOLD (1 cycle):
  - ram_rw = 0; ram_addr is held.
  - On the closing edge, a read loads ram_dout into the winner's rdata; a write leaves rdata unchanged.
  - The winner's ack register is set.
  - Next state is IDLE.
- The ack register clears automatically after one cycle. ack0 and ack1 are never high together.
- Requesters must drop req, or present a new transaction, in the cycle after ack. A req still high one cycle after ack is treated as a new request.
- Outputs in IDLE: ram_rw = 0; ram_addr and ram_din hold their last values.
- Reset values (applied immediately on clr low):
  - state = INIT (with macro) or IDLE (without).
  - ram_rw = 0, ram_addr = 0, ram_din = 0.
  - ack0 = ack1 = 0, rdata0 = rdata1 = 0.
  - `last` = 1, so port 0 wins the first tie.
  - busy = 1 with macro, 0 without.
- Reset mid-transaction: the transaction is abandoned and no ack is issued. ram_rw drops asynchronously, so a write in ACCESS without a completed rising edge does not commit.

## Timing
- req seen high at edge E0 (IDLE): ACCESS in cycle E0..E1, HOLD in E1..E2, ack high in E2..E3.
- req-to-ack latency: 3 cycles. Read data is valid together with ack.
- Back-to-back: a new transaction can be granted at the edge that ends the ack cycle. Sustained throughput is one transaction per 3 cycles.
- Both ports requesting continuously alternate grants: 0, 1, 0, 1, ...
- ram_dout is sampled one full cycle after ram_addr settles, so the RAM may have a combinational or a 1-cycle registered read.

## Configuration
- RAM_4X16_ARB_INIT_EN defined:
  - After clr rises, INIT writes 16'h0000 to addresses 0..2**ADDR_W-1, one per cycle, with ram_rw = 1 (4 cycles at default).
  - busy stays 1 and no request is granted during INIT.
  - After the last address, the next state is IDLE. The first grant edge is the 5th rising edge after clr release.
- RAM_4X16_ARB_INIT_EN undefined: the INIT state and its counter are not built, and reset enters IDLE directly.

## Test plan
- Single write then read on port 0: write 16'hA5C3 to addr 2, then read addr 2 -> ack0 3 cycles after each req; rdata0 = 16'hA5C3 in the ack cycle; ack1 never high.
- Simultaneous requests after reset: port 0 reads addr 1 and port 1 writes 16'h1234 to addr 1 -> port 0 is served first (rdata0 = old value), then port 1.
- Both ports held requesting for 6 transactions -> grants alternate 0, 1, 0, 1, 0, 1; each ack is exactly 3 cycles apart.
- Read isolation: port 1 writes, then port 0 reads a different address -> rdata1 is unchanged and rdata0 matches the RAM contents.
- Reset asserted during ACCESS of a write of 16'hFFFF to addr 3 -> all outputs return to their reset values immediately, no ack is issued, and a later read of addr 3 does not return 16'hFFFF.
- With RAM_4X16_ARB_INIT_EN defined: preload nonzero data, then pulse clr and hold req0 (read addr 3) high -> busy is high for 4 cycles, ram_rw is high for addrs 0..3, and the read returns 16'h0000.

Source files
------------

// File: rtl/ram_4x16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_4x16_arbiter
// Purpose  : Round-robin access controller that serialises single-word
//            read/write transactions from two requesters onto the single
//            rw/addr/data port of a 4 x 16 RAM, returning read data with a
//            one-cycle ack pulse.
// Ports    : clk                      system clock
//            clr                      asynchronous active-low reset
//            req0/1, we0/1            request and write-select per port
//            addr0/1, wdata0/1        address and write data per port
//            ack0/1, rdata0/1         completion pulse and read result
//            ram_rw/addr/din          RAM control port (driven only here)
//            ram_dout                 RAM read data
//            busy                     high whenever the FSM is not IDLE
// Config   : RAM_4X16_ARB_INIT_EN     when defined, the RAM is cleared to
//                                     zero after reset before any grant
// Revision : 1.0  initial release
// ============================================================================
module ram_4x16_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

`ifdef RAM_4X16_ARB_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t              state;
    state_t              state_nxt;
    logic                last;        // port granted most recently
    logic                win;         // port owning the current transaction
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_din;
    logic                elig0;
    logic                elig1;
    logic                grant;
    logic                grant_port;

`ifdef RAM_4X16_ARB_INIT_EN
    logic [ADDR_W-1:0]   init_cnt;
`endif

    // The req still held during the ack cycle belongs to the transaction
    // being acknowledged, so it must not be granted again.
    assign elig0 = req0 & ~ack0;
    assign elig1 = req1 & ~ack1;

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_port = 1'b0;
        ram_rw     = 1'b0;
        ram_addr   = lat_addr;
        case (state)
            ST_IDLE: begin
                if (elig0 | elig1) begin
                    grant      = 1'b1;
                    // On a tie the port not served last wins.
                    grant_port = (elig0 & elig1) ? ~last : elig1;
                    state_nxt  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ram_rw    = lat_we;
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                state_nxt = ST_IDLE;
            end
`ifdef RAM_4X16_ARB_INIT_EN
            ST_INIT: begin
                // Gated by clr so the write strobe is low while reset is
                // held, yet active in the very first cycle after release.
                ram_rw   = clr;
                ram_addr = init_cnt;
                if (init_cnt == {ADDR_W{1'b1}}) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ram_din is zero throughout INIT because lat_din is untouched there.
    assign ram_din = lat_din;
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            last     <= 1'b1;
            win      <= 1'b0;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_din  <= '0;
        end else if (grant) begin
            last     <= grant_port;
            win      <= grant_port;
            lat_we   <= grant_port ? we1    : we0;
            lat_addr <= grant_port ? addr1  : addr0;
            lat_din  <= grant_port ? wdata1 : wdata0;
`ifdef RAM_4X16_ARB_INIT_EN
        end else if (state == ST_INIT && init_cnt == {ADDR_W{1'b1}}) begin
            // Leave the last cleared address on the bus in IDLE.
            lat_addr <= init_cnt;
`endif
        end
    end

`ifdef RAM_4X16_ARB_INIT_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end
`endif

    // Completion: ack pulses for one cycle after HOLD; read data is taken
    // from the RAM on the same edge, a full cycle after ram_addr settled.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            ack0 <= (state == ST_HOLD) & ~win;
            ack1 <= (state == ST_HOLD) &  win;
            if (state == ST_HOLD && !lat_we) begin
                if (win) begin
                    rdata1 <= ram_dout;
                end else begin
                    rdata0 <= ram_dout;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_4x16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_4x16_arbiter
// Purpose  : Self-checking bench for ram_4x16_arbiter with a behavioural RAM,
//            a transaction-level reference model and directed scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_ram_4x16_arbiter;

`ifdef RAM_4X16_ARB_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif
    localparam int INIT_LEN = INIT_EN ? 4 : 0;

    logic        clk;
    logic        clr;
    logic        req0, req1, we0, we1;
    logic [1:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic        ram_rw;
    logic [1:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic        busy;

    int total;
    int bad;

    ram_4x16_arbiter #(.DATA_W(16), .ADDR_W(2)) dut (
        .clk      (clk),
        .clr      (clr),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .ram_rw   (ram_rw),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM with combinational read
    logic [15:0] ram [4];
    assign ram_dout = ram[ram_addr];
    always @(posedge clk) if (ram_rw) ram[ram_addr] <= ram_din;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // cyc numbers clock cycles; cycle 0 is the one in progress when clr
    // rises and cycle n begins at the n-th rising edge after that.
    // A grant at the edge starting cycle g: write lands at edge g+1,
    // read data and ack appear in cycle g+2, next grant possible at g+3.
    int          cyc;
    int          m_g;
    bit          m_p, m_we, m_last;
    logic [1:0]  m_a;
    logic [15:0] m_d;
    logic [15:0] mmem [4];
    logic [15:0] m_rd [2];
    int          pc;
    bit          e0, e1, w;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            cyc     = 0;
            m_g     = -10;
            m_last  = 1'b1;
            m_rd[0] = 16'h0;
            m_rd[1] = 16'h0;
        end else begin
            pc  = cyc;
            cyc = cyc + 1;
            if (INIT_EN && cyc <= INIT_LEN) mmem[2'(cyc - 1)] = 16'h0;
            if (cyc == m_g + 1 && m_we) mmem[m_a] = m_d;
            if (cyc == m_g + 2 && !m_we) m_rd[m_p] = mmem[m_a];
            e0 = req0 && !(pc == m_g + 2 && m_p == 1'b0);
            e1 = req1 && !(pc == m_g + 2 && m_p == 1'b1);
            if (pc >= m_g + 2 && pc >= INIT_LEN && (e0 || e1)) begin
                w      = (e0 && e1) ? !m_last : e1;
                m_last = w;
                m_p    = w;
                m_g    = cyc;
                m_we   = w ? we1 : we0;
                m_a    = w ? addr1 : addr0;
                m_d    = w ? wdata1 : wdata0;
            end
        end
    end

    // Compare process: every cycle out of reset, mid-cycle.
    always @(negedge clk) begin
        if (clr) begin
            chk("ack0", ack0, (cyc == m_g + 2) && !m_p);
            chk("ack1", ack1, (cyc == m_g + 2) && m_p);
            chk("rdata0", rdata0, m_rd[0]);
            chk("rdata1", rdata1, m_rd[1]);
            chk("busy", busy, (cyc < INIT_LEN) || cyc == m_g || cyc == m_g + 1);
            chk("ram_rw", ram_rw, (cyc < INIT_LEN) || (cyc == m_g && m_we));
            if (cyc == m_g || cyc == m_g + 1) chk("ram_addr", ram_addr, m_a);
            if (cyc < INIT_LEN) chk("ram_addr_init", ram_addr, cyc);
            if (cyc == m_g && m_we) chk("ram_din", ram_din, m_d);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic reset_checks();
        chk("rst_ram_rw", ram_rw, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_busy", busy, INIT_EN);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        clr = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        #1 reset_checks();
        @(posedge clk); #2;
        clr = 1'b1;
        repeat (INIT_EN ? 5 : 1) @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic txn(input bit p, input logic wr, input logic [1:0] a,
                       input logic [15:0] d, output int lat, output logic [15:0] rd);
        bit got;
        if (!p) begin req0 = 1'b1; we0 = wr; addr0 = a; wdata0 = d; end
        else    begin req1 = 1'b1; we1 = wr; addr1 = a; wdata1 = d; end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            // Inputs are latched at the grant edge, so scramble them after.
            if (lat == 1) begin
                if (!p) begin we0 = ~wr; addr0 = ~a; wdata0 = ~d; end
                else    begin we1 = ~wr; addr1 = ~a; wdata1 = ~d; end
            end
            got = p ? ack1 : ack0;
        end
        if (!got) chk("ack_timeout", 0, 1);
        rd = p ? rdata1 : rdata0;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    int          lat, t0, t1, n;
    logic [15:0] rd, sv;
    int          seq [$];
    int          tms [$];

    initial begin
        total = 0; bad = 0;
        clr = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        for (int i = 0; i < 4; i++) begin
            ram[i]  = 16'h1000 + 16'(i);
            mmem[i] = 16'h1000 + 16'(i);
        end
        repeat (2) @(posedge clk);
        #1 reset_checks();
        @(posedge clk); #2;
        clr = 1'b1;
        repeat (INIT_EN ? 5 : 1) @(negedge clk);

        // Single write then read on port 0
        txn(1'b0, 1'b1, 2'd2, 16'hA5C3, lat, rd);
        chk("wr_latency", lat, 3);
        txn(1'b0, 1'b0, 2'd2, 16'h0000, lat, rd);
        chk("rd_latency", lat, 3);
        chk("rd_a5c3", rd, 16'hA5C3);

        // Simultaneous requests right after reset: port 0 first
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 2'd1; wdata0 = 16'h0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 2'd1; wdata1 = 16'h1234;
        t0 = -1; t1 = -1; sv = 16'h0;
        for (int i = 1; i <= 20 && (t0 < 0 || t1 < 0); i++) begin
            @(negedge clk);
            if (ack0) begin t0 = i; sv = rdata0; req0 = 1'b0; end
            if (ack1) begin t1 = i; req1 = 1'b0; end
        end
        chk("sim_ack0_time", t0, 3);
        chk("sim_ack1_time", t1, 6);
        chk("sim_old_data", sv, INIT_EN ? 16'h0000 : 16'h1001);
        @(negedge clk);

        // Both ports held for six transactions: strict alternation
        req0 = 1'b1; we0 = 1'b0; addr0 = 2'd0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 2'd3; wdata1 = 16'h0F0F;
        n = 0;
        while (seq.size() < 6 && n < 40) begin
            @(negedge clk);
            n++;
            if (ack0) begin seq.push_back(0); tms.push_back(n); end
            if (ack1) begin seq.push_back(1); tms.push_back(n); end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_count", seq.size(), 6);
        for (int i = 0; i < seq.size(); i++) begin
            chk("rr_order", seq[i], i % 2);
            if (i > 0) chk("rr_spacing", tms[i] - tms[i-1], 3);
        end
        repeat (2) @(negedge clk);

        txn(1'b0, 1'b0, 2'd1, 16'h0, lat, rd);
        chk("rd_1234", rd, 16'h1234);

        // Read isolation
        sv = rdata1;
        txn(1'b1, 1'b1, 2'd0, 16'h7777, lat, rd);
        txn(1'b0, 1'b0, 2'd2, 16'h0, lat, rd);
        chk("iso_rdata0", rd, INIT_EN ? 16'h0000 : 16'hA5C3);
        chk("iso_rdata1", rdata1, sv);

        // Reset during ACCESS of a write
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd3; wdata0 = 16'hFFFF;
        @(posedge clk); #1;
        chk("acc_rw_high", ram_rw, 1);
        #1 clr = 1'b0;
        req0 = 1'b0;
        #1 reset_checks();
        @(posedge clk); #2;
        clr = 1'b1;
        repeat (INIT_EN ? 5 : 1) @(negedge clk);
        txn(1'b1, 1'b0, 2'd3, 16'h0, lat, rd);
        chk("no_ffff", rd == 16'hFFFF, 0);
        chk("rd_addr3", rd, INIT_EN ? 16'h0000 : 16'h0F0F);

`ifdef RAM_4X16_ARB_INIT_EN
        // INIT clears preloaded data before the held read is served
        txn(1'b0, 1'b1, 2'd3, 16'hBEEF, lat, rd);
        @(posedge clk); #2;
        clr = 1'b0;
        #1 reset_checks();
        @(posedge clk); #2;
        req0 = 1'b1; we0 = 1'b0; addr0 = 2'd3;
        clr = 1'b1;
        t0 = 0; t1 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy) t0++;
            if (ram_rw) t1++;
        end
        chk("init_busy_cycles", t0, 4);
        chk("init_rw_cycles", t1, 4);
        n = 0;
        while (!ack0 && n < 20) begin @(negedge clk); n++; end
        chk("init_ack_seen", ack0, 1);
        chk("init_read_zero", rdata0, 16'h0000);
        req0 = 1'b0;
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
